// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with glitch-free reload
// Optional programmable duty cycle: define CLK_DIV_PROG_DUTY_EN.
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_DIV_PROG_DUTY_EN
  input  logic [WIDTH-1:0] duty_val,
  output logic [WIDTH-1:0] duty_active,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             load_pending
);

  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV - DEFAULT_DIV / 2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] high_len;
  logic             wrap;
`ifdef CLK_DIV_PROG_DUTY_EN
  logic [WIDTH-1:0] duty_pending;
  logic [WIDTH-1:0] next_duty;
`endif

  always_comb begin
    div_clamped = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;
    wrap        = (cnt == div_active - WIDTH'(1));
    cnt_next    = wrap ? '0 : cnt + WIDTH'(1);
    // While stopped, a fresh load beats whatever was pending.
    next_div    = div_load ? div_clamped : pending;
`ifdef CLK_DIV_PROG_DUTY_EN
    next_duty   = div_load ? duty_val : duty_pending;
    if (duty_active == '0)
      high_len = WIDTH'(1);
    else if (duty_active >= div_active)
      high_len = div_active - WIDTH'(1);
    else
      high_len = duty_active;
`else
    high_len    = div_active - (div_active >> 1);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt          <= DEF_D - WIDTH'(1);
      pending      <= DEF_D;
      div_active   <= DEF_D;
      load_pending <= 1'b0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
`ifdef CLK_DIV_PROG_DUTY_EN
      duty_pending <= DEF_H;
      duty_active  <= DEF_H;
`endif
    end else if (!en) begin
      // Park so the first enabled cycle wraps and starts a full period.
      clk_out      <= 1'b0;
      tick         <= 1'b0;
      div_active   <= next_div;
      pending      <= next_div;
      cnt          <= next_div - WIDTH'(1);
      load_pending <= 1'b0;
`ifdef CLK_DIV_PROG_DUTY_EN
      duty_active  <= next_duty;
      duty_pending <= next_duty;
`endif
    end else begin
      cnt     <= cnt_next;
      clk_out <= (cnt_next < high_len);
      tick    <= wrap;
      if (wrap && load_pending) begin
        div_active  <= pending;
`ifdef CLK_DIV_PROG_DUTY_EN
        duty_active <= duty_pending;
`endif
      end
      // A load on the wrap cycle stays pending until the following wrap.
      if (div_load) begin
        pending      <= div_clamped;
        load_pending <= 1'b1;
`ifdef CLK_DIV_PROG_DUTY_EN
        duty_pending <= duty_val;
`endif
      end else if (wrap) begin
        load_pending <= 1'b0;
      end
    end
  end

  logic unused_def_h;
  assign unused_def_h = ^DEF_H;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog
// Duty-cycle vectors are added when CLK_DIV_PROG_DUTY_EN is defined.
module tb_clk_div_prog;

  localparam int WIDTH = 16;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic [WIDTH-1:0] duty_val;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_active;
  logic             load_pending;
`ifdef CLK_DIV_PROG_DUTY_EN
  logic [WIDTH-1:0] duty_active;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] duty;
    int               exp_div;
    int               exp_high;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(10)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .div_val      (div_val),
    .div_load     (div_load),
`ifdef CLK_DIV_PROG_DUTY_EN
    .duty_val     (duty_val),
    .duty_active  (duty_active),
`endif
    .clk_out      (clk_out),
    .tick         (tick),
    .div_active   (div_active),
    .load_pending (load_pending)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected output for the coming edge is queued, then compared after it.
  task automatic step(input logic ec, input logic et);
    logic [1:0] e;
    exp_q.push_back({ec, et});
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check("clk_out", {31'd0, clk_out}, {31'd0, e[1]});
    check("tick", {31'd0, tick}, {31'd0, e[0]});
  endtask

  task automatic run_phases(input int d, input int h, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int ph;
      ph = (start + i) % d;
      step(ph < h, ph == 0);
    end
  endtask

  task automatic load_stopped(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] dt);
    @(negedge clk_in);
    en       = 1'b0;
    div_val  = d;
    duty_val = dt;
    div_load = 1'b1;
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    div_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_val = '0; div_load = 1'b0; duty_val = '0;

    vecs.push_back('{div: 16'd4, duty: 16'd2, exp_div: 4, exp_high: 2});
    vecs.push_back('{div: 16'd5, duty: 16'd3, exp_div: 5, exp_high: 3});
    vecs.push_back('{div: 16'd2, duty: 16'd1, exp_div: 2, exp_high: 1});
    vecs.push_back('{div: 16'd0, duty: 16'd1, exp_div: 2, exp_high: 1});
    vecs.push_back('{div: 16'd1, duty: 16'd1, exp_div: 2, exp_high: 1});
    vecs.push_back('{div: 16'd3, duty: 16'd2, exp_div: 3, exp_high: 2});
    vecs.push_back('{div: 16'd7, duty: 16'd4, exp_div: 7, exp_high: 4});
`ifdef CLK_DIV_PROG_DUTY_EN
    vecs.push_back('{div: 16'd8, duty: 16'd2, exp_div: 8, exp_high: 2});
    vecs.push_back('{div: 16'd8, duty: 16'd0, exp_div: 8, exp_high: 1});
    vecs.push_back('{div: 16'd8, duty: 16'd9, exp_div: 8, exp_high: 7});
`endif

    repeat (2) @(posedge clk_in);
    #1;
    check("rst clk_out", {31'd0, clk_out}, 32'd0);
    check("rst tick", {31'd0, tick}, 32'd0);
    check("rst div_active", {16'd0, div_active}, 32'd10);
    check("rst load_pending", {31'd0, load_pending}, 32'd0);
`ifdef CLK_DIV_PROG_DUTY_EN
    check("rst duty_active", {16'd0, duty_active}, 32'd5);
`endif
    @(negedge clk_in);
    rst = 1'b0;

    foreach (vecs[i]) begin
      load_stopped(vecs[i].div, vecs[i].duty);
      check("vec div_active", {16'd0, div_active}, vecs[i].exp_div);
      check("vec load_pending", {31'd0, load_pending}, 32'd0);
      en = 1'b1;
      run_phases(vecs[i].exp_div, vecs[i].exp_high, 0, 2 * vecs[i].exp_div + 1);
      @(negedge clk_in);
      en = 1'b0;
      step(1'b0, 1'b0);
    end

    // Reload mid-period: D=10 running, load D=3 at cnt=4.
    load_stopped(16'd10, 16'd5);
    en = 1'b1;
    run_phases(10, 5, 0, 5);
    @(negedge clk_in);
    div_val  = 16'd3;
    duty_val = 16'd2;
    div_load = 1'b1;
    run_phases(10, 5, 5, 1);
    check("mid load_pending", {31'd0, load_pending}, 32'd1);
    check("mid div_active old", {16'd0, div_active}, 32'd10);
    @(negedge clk_in);
    div_load = 1'b0;
    run_phases(10, 5, 6, 4);
    check("mid still pending", {31'd0, load_pending}, 32'd1);
    step(1'b1, 1'b1);
    check("mid div_active new", {16'd0, div_active}, 32'd3);
    check("mid load_pending clr", {31'd0, load_pending}, 32'd0);
    run_phases(3, 2, 1, 9);

    // Reset mid-period: D=7 with cnt=3, then restart with default ratio.
    load_stopped(16'd7, 16'd4);
    en = 1'b1;
    run_phases(7, 4, 0, 4);
    @(negedge clk_in);
    rst = 1'b1;
    step(1'b0, 1'b0);
    check("rst2 div_active", {16'd0, div_active}, 32'd10);
    check("rst2 load_pending", {31'd0, load_pending}, 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    run_phases(10, 5, 0, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
